// File: rtl/multi_pause_control_pkg.sv
// multi_pause_control_pkg: shared types for the per-channel clock pause controller
package multi_pause_control_pkg;
   localparam int RATE_COUNTER_WIDTH = 4;
   typedef logic [RATE_COUNTER_WIDTH-1:0] count_t;
   typedef enum logic [2:0] {IDLE, ARMED, PAUSED, RESUME_WAIT, HOLDOFF} pause_state_e;
   typedef struct packed {
      logic rising_edge;
      logic falling_edge;
   } generated_events_s;
   typedef struct packed {
      logic   pause_active;
      count_t pause_duration;
      logic   locked;
   } pause_status_s;
   typedef struct packed {
      logic              clk;
      generated_events_s events;
      pause_status_s     status;
   } clock_state_s;
   typedef struct packed {
      logic   polarity;
      logic   timed;
      count_t limit;
   } pause_cfg_s;
endpackage

// File: rtl/multi_pause_control_if.sv
// multi_pause_control_if: clock generator inputs, pause controls and gated clock outputs
interface multi_pause_control_if #(parameter int CHANNELS = 4);
   import multi_pause_control_pkg::*;
   logic                        generation_en;
   generated_events_s [CHANNELS-1:0] clk_events;
   logic [CHANNELS-1:0]         io_clk;
   logic [CHANNELS-1:0]         io_clk_locked;
   logic [CHANNELS-1:0]         pause_en;
   logic                        group_pause;
   logic [CHANNELS-1:0]         group_mask;
   logic [CHANNELS-1:0]         pause_polarity;
   logic [CHANNELS-1:0]         timed_mode;
   count_t [CHANNELS-1:0]       pause_limit;
   clock_state_s [CHANNELS-1:0] pausable_clock;
   logic [CHANNELS-1:0]         pause_done;
   logic [CHANNELS-1:0]         duration_sat;
   logic                        any_paused;
   modport master (
      output generation_en, clk_events, io_clk, io_clk_locked, pause_en, group_pause,
             group_mask, pause_polarity, timed_mode, pause_limit,
      input  pausable_clock, pause_done, duration_sat, any_paused
   );
   modport slave (
      input  generation_en, clk_events, io_clk, io_clk_locked, pause_en, group_pause,
             group_mask, pause_polarity, timed_mode, pause_limit,
      output pausable_clock, pause_done, duration_sat, any_paused
   );
endinterface

// File: rtl/multi_pause_control_pause_channel.sv
// pause_channel: one channel's pause FSM, suppressed-period counter and clock output mux
module pause_channel
   import multi_pause_control_pkg::*;
#(
   parameter bit SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              req,
   input  logic              io_clk,
   input  logic              locked,
   input  generated_events_s events,
   input  pause_cfg_s        cfg,
   output clock_state_s      state,
   output logic              done,
   output logic              sat,
   output logic              active
);
   pause_state_e st, st_n;
   pause_cfg_s   cfg_l, cfg_n;
   count_t       cnt, cnt_n, cnt_inc;
   logic         sat_n, aligned, ev, hit;
   always_comb begin
      ev = cfg_l.polarity ? events.rising_edge : events.falling_edge;
      cnt_inc = (&cnt && SATURATE) ? cnt : cnt + 1'b1;
      aligned = io_clk == (st == IDLE ? cfg.polarity : cfg_l.polarity);
      hit = ev && cfg_l.timed && cfg_l.limit != '0 && cnt_inc == cfg_l.limit;
      st_n = st;
      cfg_n = cfg_l;
      cnt_n = cnt;
      sat_n = sat;
      done = 1'b0;
      case (st)
         IDLE:        st_n = req ? (aligned ? PAUSED : ARMED) : IDLE;
         ARMED:       st_n = !req ? IDLE : (aligned ? PAUSED : ARMED);
         PAUSED: begin
            cnt_n = ev ? cnt_inc : cnt;
            sat_n = sat | (ev & (&cnt_inc));
            st_n = (hit || !req) ? RESUME_WAIT : PAUSED;
            done = hit & clk_en;
         end
         RESUME_WAIT: st_n = aligned ? ((cfg_l.timed && req) ? HOLDOFF : IDLE) : RESUME_WAIT;
         HOLDOFF:     st_n = req ? HOLDOFF : IDLE;
         default:     st_n = IDLE;
      endcase
      // configuration is captured only when a new pause begins
      if (st == IDLE && req) begin
         cfg_n = cfg;
         cnt_n = '0;
         sat_n = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st <= IDLE;
         cfg_l <= '0;
         cnt <= '0;
         sat <= 1'b0;
      end else if (clk_en) begin
         st <= st_n;
         cfg_l <= cfg_n;
         cnt <= cnt_n;
         sat <= sat_n;
      end
   end
   assign active = st == PAUSED || st == RESUME_WAIT;
   assign state = {active ? cfg_l.polarity : io_clk, active ? 2'b00 : events, active, cnt, locked};
endmodule

// File: rtl/multi_pause_control.sv
// multi_pause_control: glitch-free per-channel clock pause with timed and group pausing
module multi_pause_control
   import multi_pause_control_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter bit SATURATE = 1'b1
) (
   input logic clk,
   input logic rst,
   input logic clk_en,
   multi_pause_control_if.slave bus
);
   logic [CHANNELS-1:0]         req, active, done, sat;
   clock_state_s [CHANNELS-1:0] st;
   assign req = {CHANNELS{bus.generation_en}} & (bus.pause_en | ({CHANNELS{bus.group_pause}} & bus.group_mask));
   assign bus.pausable_clock = st;
   assign bus.pause_done = done;
   assign bus.duration_sat = sat;
   assign bus.any_paused = |active;
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      pause_cfg_s cfg;
      assign cfg = {bus.pause_polarity[c], bus.timed_mode[c], bus.pause_limit[c]};
      pause_channel #(.SATURATE(SATURATE)) u_ch (
         .clk(clk),
         .rst(rst),
         .clk_en(clk_en),
         .req(req[c]),
         .io_clk(bus.io_clk[c]),
         .locked(bus.io_clk_locked[c]),
         .events(bus.clk_events[c]),
         .cfg(cfg),
         .state(st[c]),
         .done(done[c]),
         .sat(sat[c]),
         .active(active[c])
      );
   end
endmodule

// File: doc/multi_pause_control.md
Name: multi_pause_control

Overview:
- Per-channel pause controller for up to CHANNELS generated clocks.
- Each channel freezes its clock at a programmable level without glitches. Entry and exit both wait until the live clock level matches the hold level.
- Adds timed pauses that resume automatically after N suppressed periods, a masked group-pause input, latched per-pause configuration and a selectable saturate/wrap duration counter.
- Sits between the clock generators and the IO clock fan-out in the generation path.

Parameters:
- CHANNELS, 4, number of independent channels (1..32).
- SATURATE, 1, 1 = duration counter saturates at all-ones; 0 = wraps to 0.

Ports:
- sys_dom_i  in  common_p::clk_dom_s  system domain: .clk (single clock), .sync_rst (synchronous, active-high reset), .clk_en (cycle qualifier).
- generation_en_i  in  1  global enable; when low, all channels are forced toward IDLE exit (see Behaviour).
- clk_events_i  in  clks_alot_p::generated_events_s [CHANNELS]  per-channel rising_edge/falling_edge events.
- io_clk_i  in  CHANNELS  live clock level per channel.
- io_clk_locked_i  in  CHANNELS  lock status per channel, passed through.
- pause_en_i  in  CHANNELS  per-channel pause request (level).
- group_pause_i  in  1  group pause request.
- group_mask_i  in  CHANNELS  channels that obey group_pause_i.
- pause_polarity_i  in  CHANNELS  hold level while paused.
- timed_mode_i  in  CHANNELS  1 = auto-resume after pause_limit_i periods.
- pause_limit_i  in  clks_alot_p::RATE_COUNTER_WIDTH x CHANNELS  auto-resume period count.
- pausable_clock_o  out  clks_alot_p::clock_state_s [CHANNELS]  gated clock, events, status.
- pause_done_o  out  CHANNELS  1-cycle pulse when a timed pause expires.
- duration_sat_o  out  CHANNELS  sticky flag: counter hit all-ones during the current/last pause.
- any_paused_o  out  1  OR of all channels in PAUSED or RESUME_WAIT.

Behaviour:
- Requests and alignment:
  - req[c] = generation_en_i & (pause_en_i[c] | (group_pause_i & group_mask_i[c])).
  - aligned[c] = (io_clk_i[c] == pol_l[c]).
- All state updates are qualified by clk_en. When clk_en is low, state, counters and flags hold, and pause_done_o is 0.
- Latching: pol_l and mode_l/limit_l latch from the inputs on IDLE->ARMED or IDLE->PAUSED. Input changes while paused are ignored. In IDLE, aligned uses pause_polarity_i directly.
- Per-channel FSM, encoding in package:
  - IDLE: req & aligned -> PAUSED; req & ~aligned -> ARMED.
  - ARMED: ~req -> IDLE; aligned -> PAUSED.
  - PAUSED: count one suppressed period per event: rising_edge if pol_l=1, falling_edge if pol_l=0.
    - Manual mode, or timed mode with limit_l=0: ~req -> RESUME_WAIT.
    - Timed mode, limit_l>0: when the counting event makes count == limit_l -> RESUME_WAIT and pulse pause_done_o for that cycle. ~req also exits early, with no done pulse.
  - RESUME_WAIT: when aligned -> HOLDOFF if (mode_l timed & req), else IDLE.
  - HOLDOFF: ~req -> IDLE. A timed pause re-arms only after the request drops.
- Duration counter:
  - Cleared to 0 on entry to ARMED or direct entry to PAUSED.
  - Increments only in PAUSED.
  - Holds after resume for status readback.
  - SATURATE=1: stops at all-ones and sets duration_sat_o. SATURATE=0: wraps, and duration_sat_o is still set at the all-ones value.
  - duration_sat_o clears on the next pause entry.
- Outputs, registered state with 1-cycle latency from the aligned cycle:
  - In PAUSED/RESUME_WAIT: .clk = pol_l and .events = 0.
  - Otherwise: .clk = io_clk_i[c] and .events = clk_events_i[c].
  - .status.pause_active = (PAUSED|RESUME_WAIT).
  - .status.pause_duration = counter.
  - .status.locked = io_clk_locked_i[c].
- Simultaneous events:
  - Limit reached in the same cycle that req drops: go to RESUME_WAIT and pulse done.
  - A counting event and the exit in the same cycle: the count includes the event.
- sync_rst: all channels to IDLE; counter 0; pol_l 0; pause_done_o 0; duration_sat_o 0; any_paused_o 0. Reset mid-pause releases the clock on the next cycle, with no alignment wait.
- generation_en_i low clears req, which exits through the normal aligned path.

Decomposition:
- clks_alot_p additions:
  - pause_state_e (IDLE, ARMED, PAUSED, RESUME_WAIT, HOLDOFF).
  - pause_cfg_s {polarity, timed, limit}.
- Sub-module pause_channel, one channel's FSM, counter and output mux, generated CHANNELS times. The top level holds only request merging, any_paused_o and port slicing.

Test Plan:
- Manual pause, ch0, polarity=1, io_clk low at request:
  - ARMED until io_clk rises; PAUSED one cycle later.
  - .clk held 1, events 0.
  - Drop request after 5 rising edges -> pause_duration=5; release on the next high-level cycle.
- Timed mode, limit=3, polarity=0, request held high:
  - pause_done_o pulses exactly once on the 3rd falling edge; duration=3.
  - Channel sits in HOLDOFF, not re-paused, until the request drops.
- Group pause with group_mask=4'b0101:
  - Only ch0 and ch2 pause; any_paused_o=1; ch1 and ch3 outputs are bit-identical to their inputs.
- Saturation, SATURATE=1, counter forced near all-ones (RATE_COUNTER_WIDTH small in bench):
  - Counter stops at all-ones and duration_sat_o=1. SATURATE=0 build: wraps to 0 with the flag set.
- Polarity toggled while paused, and sync_rst mid-pause:
  - The polarity change is ignored.
  - Reset returns all outputs to reset values the next cycle.
  - clk_en low holds the count across edges.
